// File: rtl/truth_table_pkg.sv
// rtl/truth_table_pkg.sv - shared state encoding and sizing helpers for the truth-table sweeper
package truth_table_pkg;

  localparam int N_IN_MAX = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    DONE  = 2'd2
  } tt_state_e;

  function automatic int tt_size(input int n);
    return 1 << n;
  endfunction

endpackage

// File: rtl/tt_term_eval.sv
// rtl/tt_term_eval.sv - combinational SoP/PoS evaluation of one truth-table row
// m is the minterm sum at idx; M is the maxterm product at idx (0 when maxterm idx is present).
module tt_term_eval
  import truth_table_pkg::*;
#(
  parameter  int N_IN = 4,
  localparam int T    = tt_size(N_IN)
) (
  input  logic [T-1:0]    lmin,
  input  logic [T-1:0]    lmax,
  input  logic [N_IN-1:0] idx,
  output logic            m,
  output logic            M
);

  assign m = lmin[idx];
  assign M = ~lmax[idx];

endmodule

// File: rtl/truth_table_sweeper.sv
// rtl/truth_table_sweeper.sv - sweeps all input rows, streams (idx, m, M) beats and counts SoP/PoS disagreements
// Optional macro SWEEP_STOP_ON_MISMATCH_EN: end the sweep at the first disagreeing beat.
module truth_table_sweeper
  import truth_table_pkg::*;
#(
  parameter  int N_IN = 4,
  localparam int T    = tt_size(N_IN)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [T-1:0]    minterm_mask,
  input  logic [T-1:0]    maxterm_mask,
  output logic            busy,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [N_IN-1:0] out_idx,
  output logic            out_m,
  output logic            out_M,
  output logic            done,
  output logic [N_IN:0]   mismatch_cnt,
  output logic            equiv
);

  tt_state_e       r_state;
  tt_state_e       w_state_next;
  logic [T-1:0]    r_lmin;
  logic [T-1:0]    r_lmax;
  logic [N_IN-1:0] r_idx;
  logic [N_IN:0]   r_cnt;
  logic [N_IN:0]   w_cnt_next;
  logic            r_done;
  logic            r_equiv;
  logic            w_m;
  logic            w_M;
  logic            w_mis;
  logic            w_last;
  logic            w_stop;
  logic            w_accept;
  logic            w_xfer;
  logic            w_finish;

  tt_term_eval #(.N_IN(N_IN)) u_eval (
    .lmin (r_lmin),
    .lmax (r_lmax),
    .idx  (r_idx),
    .m    (w_m),
    .M    (w_M)
  );

  assign w_mis      = w_m ^ w_M;
  assign w_last     = &r_idx;
  assign w_cnt_next = r_cnt + {{N_IN{1'b0}}, w_mis};

`ifdef SWEEP_STOP_ON_MISMATCH_EN
  assign w_stop = w_mis;
`else
  assign w_stop = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    busy         = 1'b0;
    out_valid    = 1'b0;
    w_accept     = 1'b0;
    w_xfer       = 1'b0;
    w_finish     = 1'b0;
    case (r_state)
      IDLE, DONE: begin
        if (start) begin
          w_accept     = 1'b1;
          w_state_next = SWEEP;
        end
      end
      SWEEP: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        w_xfer    = out_ready;
        if (out_ready && (w_last || w_stop)) begin
          w_finish     = 1'b1;
          w_state_next = DONE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  // Finishing the sweep parks idx at 0 unless it stopped early on a failing row.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_lmin  <= '0;
      r_lmax  <= '0;
      r_idx   <= '0;
      r_cnt   <= '0;
      r_done  <= 1'b0;
      r_equiv <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_accept) begin
        r_lmin  <= minterm_mask;
        r_lmax  <= maxterm_mask;
        r_idx   <= '0;
        r_cnt   <= '0;
        r_equiv <= 1'b0;
      end else if (w_xfer) begin
        r_cnt <= w_cnt_next;
        if (w_finish) begin
          r_done  <= 1'b1;
          r_equiv <= (w_cnt_next == '0);
          r_idx   <= w_stop ? r_idx : '0;
        end else begin
          r_idx <= r_idx + 1'b1;
        end
      end
    end
  end

  assign out_idx      = r_idx;
  assign out_m        = out_valid & w_m;
  assign out_M        = out_valid & w_M;
  assign done         = r_done;
  assign mismatch_cnt = r_cnt;
  assign equiv        = r_equiv;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// tb/tb_truth_table_sweeper.sv - randomized self-checking bench for truth_table_sweeper (N_IN=4 and N_IN=2)
module tb_truth_table_sweeper;

  localparam int T = 16;
`ifdef SWEEP_STOP_ON_MISMATCH_EN
  localparam bit STOP_EN = 1'b1;
`else
  localparam bit STOP_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        out_ready = 1'b0;
  logic [15:0] minterm_mask = '0;
  logic [15:0] maxterm_mask = '0;
  logic        busy, out_valid, out_m, out_M, done, equiv;
  logic [3:0]  out_idx;
  logic [4:0]  mismatch_cnt;

  logic        s_start = 1'b0;
  logic        s_ready = 1'b1;
  logic [3:0]  s_min = '0;
  logic [3:0]  s_max = '0;
  logic        s_busy, s_valid, s_m, s_M, s_done, s_equiv;
  logic [1:0]  s_idx;
  logic [2:0]  s_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  truth_table_sweeper #(.N_IN(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .minterm_mask (minterm_mask),
    .maxterm_mask (maxterm_mask),
    .busy         (busy),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_idx      (out_idx),
    .out_m        (out_m),
    .out_M        (out_M),
    .done         (done),
    .mismatch_cnt (mismatch_cnt),
    .equiv        (equiv)
  );

  truth_table_sweeper #(.N_IN(2)) dut_small (
    .clk          (clk),
    .reset        (reset),
    .start        (s_start),
    .minterm_mask (s_min),
    .maxterm_mask (s_max),
    .busy         (s_busy),
    .out_valid    (s_valid),
    .out_ready    (s_ready),
    .out_idx      (s_idx),
    .out_m        (s_m),
    .out_M        (s_M),
    .done         (s_done),
    .mismatch_cnt (s_cnt),
    .equiv        (s_equiv)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Model: row i is in the SoP when minterm bit i is set; the PoS is 0 at row i when maxterm bit i is set.
  task automatic run_sweep(input logic [15:0] mn, input logic [15:0] mx, input int stall_idx,
                           input int stall_len, input bit rand_ready, input int start_idx,
                           input int reset_idx);
    int exp_idx = 0;
    int cnt     = 0;
    int cycles  = 0;
    int stalled = 0;
    int fin_idx = 0;
    bit finished = 1'b0;
    bit aborted  = 1'b0;
    bit rdy, mis, em, e_m_pos;
    @(negedge clk);
    minterm_mask = mn;
    maxterm_mask = mx;
    start = 1'b1;
    @(negedge clk);
    minterm_mask = 16'($urandom);
    maxterm_mask = 16'($urandom);
    while (!finished && !aborted && cycles < 400) begin
      start = 1'b0;
      rdy = rand_ready ? ($urandom_range(3) != 0) : 1'b1;
      if (exp_idx == stall_idx && stalled < stall_len) begin
        rdy = 1'b0;
        stalled++;
      end
      out_ready = rdy;
      if (exp_idx == reset_idx) begin
        reset = 1'b1;
        #1;
        check_eq("rst_async_outs",
                 {busy, out_valid, out_m, out_M, done, equiv, out_idx, mismatch_cnt}, '0);
        reset = 1'b0;
        aborted = 1'b1;
      end else begin
        em      = mn[exp_idx];
        e_m_pos = !mx[exp_idx];
        check_eq("valid", out_valid, 1);
        check_eq("busy", busy, 1);
        check_eq("idx", out_idx, exp_idx);
        check_eq("m", out_m, em);
        check_eq("M", out_M, e_m_pos);
        check_eq("cnt_run", mismatch_cnt, cnt);
        check_eq("done_low", done, 0);
        if (exp_idx == start_idx) begin
          start = 1'b1;
          minterm_mask = ~mn;
          maxterm_mask = mn;
        end
        if (rdy) begin
          mis = (em != e_m_pos);
          cnt += int'(mis);
          if (exp_idx == T - 1 || (STOP_EN && mis)) begin
            finished = 1'b1;
            fin_idx  = exp_idx;
            start    = 1'b1;
          end else begin
            exp_idx++;
          end
        end
        @(negedge clk);
        cycles++;
      end
    end
    start = 1'b0;
    out_ready = 1'b0;
    if (aborted) begin
      repeat (3) begin
        @(negedge clk);
        check_eq("abort_no_done", {done, busy, out_valid, equiv, mismatch_cnt}, 0);
      end
    end else if (!finished) begin
      check_eq("timeout", 0, 1);
    end else begin
      check_eq("done_pulse", done, 1);
      check_eq("busy_end", busy, 0);
      check_eq("valid_end", out_valid, 0);
      check_eq("mM_gated", {out_m, out_M}, 0);
      check_eq("cnt_final", mismatch_cnt, cnt);
      check_eq("equiv", equiv, cnt == 0);
      check_eq("idx_done", out_idx, (STOP_EN && cnt != 0) ? fin_idx : 0);
      @(negedge clk);
      check_eq("done_once", done, 0);
      check_eq("start_on_last_ignored", busy, 0);
      check_eq("cnt_hold", mismatch_cnt, cnt);
      check_eq("equiv_hold", equiv, cnt == 0);
    end
  endtask

  task automatic run_small(input logic [3:0] mn, input logic [3:0] mx);
    int k   = 0;
    int cyc = 0;
    @(negedge clk);
    s_min = mn;
    s_max = mx;
    s_start = 1'b1;
    @(negedge clk);
    s_start = 1'b0;
    while (k < 4 && cyc < 50) begin
      check_eq("s_valid", s_valid, 1);
      check_eq("s_idx", s_idx, k);
      check_eq("s_m", s_m, mn[k]);
      check_eq("s_M", s_M, !mx[k]);
      k++;
      cyc++;
      @(negedge clk);
    end
    if (k < 4) check_eq("s_timeout", 0, 1);
    check_eq("s_done", s_done, 1);
    check_eq("s_valid_end", s_valid, 0);
    check_eq("s_cnt", s_cnt, 0);
    check_eq("s_equiv", s_equiv, 1);
  endtask

  initial begin
    logic [15:0] mn, mx;
    #2 reset = 1'b1;
    #1;
    check_eq("reset_outs",
             {busy, out_valid, out_m, out_M, done, equiv, out_idx, mismatch_cnt}, '0);
    check_eq("reset_outs_small",
             {s_busy, s_valid, s_m, s_M, s_done, s_equiv, s_idx, s_cnt}, '0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    run_sweep(16'hE5AB, 16'h1A54, -1, 0, 1'b0, -1, -1);
    run_sweep(16'hE5AB, 16'h1A50, -1, 0, 1'b0, -1, -1);
    run_sweep(16'hE5AB, 16'h1A54, 5, 3, 1'b0, -1, -1);
    run_sweep(16'hE5AB, 16'h1A54, -1, 0, 1'b0, -1, 7);
    run_sweep(16'hE5AB, 16'h1A54, -1, 0, 1'b0, 3, -1);
    run_small(4'h6, 4'h9);
    run_small(4'h3, 4'hC);

    for (int r = 0; r < 10; r++) begin
      mn = 16'($urandom);
      mx = (r % 2 == 0) ? ~mn : 16'($urandom);
      if (r % 4 == 1) mx = ~mn ^ (16'h1 << $urandom_range(15));
      run_sweep(mn, mx, $urandom_range(15), $urandom_range(4), 1'b1, -1, -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/truth_table_sweeper.md
Name: truth_table_sweeper

Overview:
- Parametrised sequential successor to the 4-input SoP/PoS exercise blocks.
- Latches a minterm mask (SoP form) and a maxterm mask (PoS form) for an N_IN-input function.
- Sweeps every input combination 0..2^N_IN-1 and streams (idx, m, M) beats over a valid/ready handshake.
- Counts SoP/PoS disagreements and reports equivalence on completion; serves as the self-checking engine for truth-table exercises.

Parameters:
- N_IN, 4, number of function inputs (1..8); table size T = 2^N_IN.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  begin a sweep; masks sampled in the same cycle.
- minterm_mask  in  T  bit i=1: minterm i is in the SoP sum.
- maxterm_mask  in  T  bit i=1: maxterm i is in the PoS product.
- busy  out  1  high while sweeping.
- out_valid  out  1  beat available.
- out_ready  in  1  consumer accepts beat.
- out_idx  out  N_IN  current input combination; MSB = first variable (x).
- out_m  out  1  SoP value at out_idx.
- out_M  out  1  PoS value at out_idx.
- done  out  1  one-cycle pulse when the sweep ends.
- mismatch_cnt  out  N_IN+1  number of transferred beats with out_m != out_M.
- equiv  out  1  1 when the last completed sweep had mismatch_cnt == 0.

Behaviour:
- Reset (async, any state): state=IDLE; busy, out_valid, out_idx, out_m, out_M, done, mismatch_cnt, equiv all 0. Latched masks cleared to 0.
- FSM states: IDLE, SWEEP, DONE.
  - IDLE/DONE + start=1: latch both masks, clear mismatch_cnt and equiv, set idx=0, go to SWEEP.
  - SWEEP: start is ignored; masks are not re-sampled.
  - DONE holds mismatch_cnt and equiv until the next accepted start. DONE behaves like IDLE for start.
- Evaluation, combinational from latched masks and idx:
  - m = OR over i of (lmin[i] & (idx==i)).
  - M = AND over i of (~lmax[i] | (idx!=i)).
  - Equivalently m=lmin[idx] and M=~lmax[idx]; either implementation is acceptable.
  - out_m/out_M are forced to 0 when out_valid=0.
- Latency: out_valid rises the cycle after start is accepted, with out_idx=0.
- Handshake:
  - A transfer occurs when out_valid & out_ready.
  - While out_valid=1 and out_ready=0, out_idx/out_m/out_M stay stable.
  - out_valid never drops without a transfer, except on reset.
- On transfer:
  - mismatch_cnt += (m != M).
  - If idx == T-1: go to DONE; out_valid=0 next cycle; done=1 for exactly one cycle; equiv = (final count == 0), where the final count includes the last beat.
  - Otherwise idx+1 next cycle and out_valid stays 1. Back-to-back transfers: one beat per cycle.
- mismatch_cnt width N_IN+1 holds the maximum value T without wrapping. idx never wraps within a sweep.
- busy = (state == SWEEP).
- Reset mid-sweep: abort immediately; done is not pulsed and equiv stays 0.
- start asserted in the same cycle as the final transfer is ignored. It is accepted in DONE.

Optional Feature:
- Macro: SWEEP_STOP_ON_MISMATCH_EN.
- Defined: the first transferred beat with m != M ends the sweep as if it were the last beat. Go to DONE, pulse done, mismatch_cnt=1, equiv=0. out_idx keeps the failing index while in DONE, with out_valid=0.
- Undefined: full sweep is always performed; out_idx returns to 0 in DONE.

Decomposition:
- Package truth_table_pkg holds:
  - the state enum (IDLE, SWEEP, DONE);
  - localparam function tt_size(n) = 1<<n;
  - the constant N_IN_MAX = 8.
- One natural sub-module: tt_term_eval. Purely combinational, parametrised by N_IN. Inputs lmin, lmax, idx; outputs m, M. Reusable by the exercise testbenches.

Test Plan:
1. Equivalent masks, ready tied high: N_IN=4, minterm=0xE5AB, maxterm=0x1A54, start. Expect 16 consecutive beats idx 0..15 with m==M, and m=1 at idx {0,1,3,5,7,8,10,13,14,15}. done pulses once the cycle after idx 15; mismatch_cnt=0, equiv=1.
2. Single mismatch: minterm=0xE5AB, maxterm=0x1A50. Expect idx 2 beat with m=0, M=1; mismatch_cnt=1, equiv=0. With SWEEP_STOP_ON_MISMATCH_EN: done right after the idx 2 transfer, and out_idx holds 2.
3. Backpressure: drop out_ready for 3 cycles while out_idx=5. Expect out_idx=5 and m/M held stable with out_valid=1; no count change; the sweep resumes at 6 and total beats = 16.
4. Reset mid-sweep: assert reset at out_idx=7. Expect all outputs 0 asynchronously, no done pulse, state IDLE. A new start then sweeps from idx 0.
5. Start during SWEEP: pulse start at idx 3 with different masks. Expect it ignored: original masks are used and 16 beats are produced.
6. N_IN=2 instance, minterm=0x6, maxterm=0x9 (XOR). Expect 4 beats with m/M pattern 0,1,1,0; equiv=1; mismatch_cnt width 3.
